// File: rtl/switch_in_pkg.sv
// Shared register addresses and edge-mode encodings for the switch input port.
package switch_in_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/switch_in_debounce.sv
// One-bit debounce filter: output follows input only after it has disagreed
// for DEBOUNCE_CYCLES consecutive cycles.
module switch_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;

    always_comb begin
        cnt_d = '0;
        q_d   = q_q;
        if (d != q_q) begin
            // Any cycle of agreement falls through to the zero default above.
            if (cnt_q == CNT_LAST) begin
                q_d = d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/switch_in_pio.sv
// Avalon-MM switch/key input port: synchroniser, optional debounce
// (SWITCH_IN_DEBOUNCE_EN), edge capture with W1C, interrupt mask and level IRQ.
module switch_in_pio
    import switch_in_pkg::*;
#(
    parameter int WIDTH           = 17,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int PCW = $clog2(SYNC_STAGES + 2);
    localparam logic [PCW-1:0] PRIME_DONE = PCW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [PCW-1:0]   prime_q, prime_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] synced, filtered, wdata, rise, fall, set_bits, clr_bits;
    logic             primed, wr_en;

    assign synced = sync_q[SYNC_STAGES-1];
    assign wdata  = writedata[WIDTH-1:0];
    assign wr_en  = chipselect & ~write_n;

    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

`ifdef SWITCH_IN_DEBOUNCE_EN
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_db
            switch_in_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk  (clk),
                .reset(reset),
                .d    (synced[i]),
                .q    (filtered[i])
            );
        end
    endgenerate
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign filtered = synced;
`endif

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Edges are ignored until the sync chain has filled after reset, so inputs
    // already high at reset do not register as rising edges.
    assign primed  = (prime_q == PRIME_DONE);
    assign prime_d = primed ? prime_q : prime_q + 1'b1;
    assign prev_d  = filtered;

    always_comb begin
        rise = filtered & ~prev_q;
        fall = ~filtered & prev_q;
        case (EDGE_MODE)
            EDGE_FALL: set_bits = fall;
            EDGE_ANY:  set_bits = rise | fall;
            default:   set_bits = rise;
        endcase
        if (!primed) set_bits = '0;
    end

    always_comb begin
        clr_bits  = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;
        capture_d = set_bits | (capture_q & ~clr_bits);
        mask_d    = (wr_en && address == ADDR_IRQMASK) ? wdata : mask_q;
        irq_d     = |(capture_q & mask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d = 32'(filtered);
            ADDR_RSVD:    readdata_d = '0;
            ADDR_IRQMASK: readdata_d = 32'(mask_q);
            ADDR_EDGECAP: readdata_d = 32'(capture_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            prime_q    <= '0;
            prev_q     <= '0;
            capture_q  <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prime_q    <= prime_d;
            prev_q     <= prev_d;
            capture_q  <= capture_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_switch_in_pio.sv
// Directed bench for switch_in_pio in the default (no debounce) build.
module tb_switch_in_pio;
    localparam int WIDTH = 17;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int checks = 0;
    int errors = 0;

    switch_in_pio #(
        .WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_MODE(0), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 17'h1FFFF;
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        // Step 1: inputs high through reset, DATA appears after 3 cycles
        reset = 1'b0;
        tick(2);
        check("data_latency_2", readdata, 32'h0);
        tick();
        check("data_latency_3", readdata, 32'h0001FFFF);
        address = 2'd3;
        tick();
        check("no_capture_after_prime", readdata, 32'h0);

        // Step 2: falling edges ignored, then rising on bits 0 and 2
        in_port = '0;
        tick(4);
        check("fall_not_captured", readdata, 32'h0);
        in_port = 17'h00005;
        tick(4);
        check("edgecap_rise", readdata, 32'h00000005);
        check("irq_unmasked", {31'b0, irq}, 32'h0);
        address = 2'd1;
        tick();
        check("rsvd_reads_0", readdata, 32'h0);
        address = 2'd0;
        tick();
        check("data_value", readdata, 32'h00000005);

        // Step 3: mask bit2, then clear it
        wr(2'd2, 32'h00000004);
        check("irq_same_cycle_as_mask", {31'b0, irq}, 32'h0);
        tick();
        check("irq_after_mask", {31'b0, irq}, 32'h1);
        check("irqmask_read", readdata, 32'h00000004);
        wr(2'd3, 32'h00000004);
        check("irq_held_at_clear", {31'b0, irq}, 32'h1);
        address = 2'd3;
        tick();
        check("irq_after_clear", {31'b0, irq}, 32'h0);
        check("edgecap_after_clear", readdata, 32'h00000001);

        // Step 4: plain clear of bit0, then clear coinciding with a rising edge
        in_port = 17'h00004;
        wr(2'd3, 32'h00000001);
        address = 2'd3;
        tick(4);
        check("edgecap_cleared", readdata, 32'h0);
        in_port = 17'h00005;
        tick(2);
        wr(2'd3, 32'h00000001);
        address = 2'd3;
        tick();
        check("set_wins_over_clear", readdata, 32'h00000001);

        // Bits above WIDTH are not stored
        wr(2'd2, 32'hFFFFFFFF);
        address = 2'd2;
        tick();
        check("irqmask_upper_bits", readdata, 32'h0001FFFF);
        check("irq_full_mask", {31'b0, irq}, 32'h1);

        // Writes to DATA are ignored
        wr(2'd0, 32'h00000000);
        address = 2'd0;
        tick();
        check("data_write_ignored", readdata, 32'h00000005);

        // Step 6: reset while irq is high, with a write in flight
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h0000FFFF;
        tick();
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        tick();
        check("midreset_irqmask", readdata, 32'h0);
        address = 2'd3;
        tick(5);
        check("midreset_edgecap", readdata, 32'h0);
        check("midreset_irq_stays_0", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
